// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write path: FSM state encodings,
// 50 MHz default timing constants and nibble-select values.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_POST  = 3'd5,
    ST_DONE  = 3'd6
  } lcd_state_t;

  localparam int unsigned LCD_SETUP_DEF = 2;
  localparam int unsigned LCD_PULSE_DEF = 12;
  localparam int unsigned LCD_HOLD_DEF  = 1;
  localparam int unsigned LCD_GAP_DEF   = 50;
  localparam int unsigned LCD_POST_DEF  = 2000;

  localparam logic NIB_HI = 1'b1;
  localparam logic NIB_LO = 1'b0;

  function automatic logic [3:0] nibble_sel(input logic [7:0] b, input logic hi);
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/lcd_phase_counter.sv
// Phase down-counter: loads a value, counts down to zero and holds there.
module lcd_phase_counter #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_strobe.sv
// Two-nibble HD44780 write-cycle generator (upper nibble first).
// Define LCD_POST_WAIT_EN to wait out the controller execution time before oDone.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = LCD_SETUP_DEF,
  parameter int unsigned PULSE_CYCLES = LCD_PULSE_DEF,
  parameter int unsigned HOLD_CYCLES  = LCD_HOLD_DEF,
  parameter int unsigned GAP_CYCLES   = LCD_GAP_DEF,
  parameter int unsigned POST_CYCLES  = LCD_POST_DEF,
  parameter int unsigned CNT_W        = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iRS,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_RS,
  output logic       oLCD_Enabled,
  output logic       oBusy,
  output logic       oDone
);

  lcd_state_t       state_q, state_d;
  logic             hi_q, hi_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  lcd_phase_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      hi_q    <= NIB_LO;
      byte_q  <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          byte_d  = iData;
          rs_d    = iRS;
          hi_d    = NIB_HI;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: if (cnt_zero) state_d = ST_PULSE;
      ST_PULSE: if (cnt_zero) state_d = ST_HOLD;
      ST_HOLD: begin
        if (cnt_zero) begin
          if (hi_q) begin
            state_d = ST_GAP;
          end else begin
`ifdef LCD_POST_WAIT_EN
            state_d = ST_POST;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          hi_d    = NIB_LO;
          state_d = ST_SETUP;
        end
      end
      ST_POST: if (cnt_zero) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every transition changes state, so a state change is the counter's load strobe.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      ST_SETUP: cnt_load_val = CNT_W'(SETUP_CYCLES - 1);
      ST_PULSE: cnt_load_val = CNT_W'(PULSE_CYCLES - 1);
      ST_HOLD:  cnt_load_val = CNT_W'(HOLD_CYCLES - 1);
      ST_GAP:   cnt_load_val = CNT_W'(GAP_CYCLES - 1);
      ST_POST:  cnt_load_val = CNT_W'(POST_CYCLES - 1);
      default:  cnt_load_val = '0;
    endcase
  end

  always_comb begin
    oBusy        = (state_q != ST_IDLE);
    oDone        = (state_q == ST_DONE);
    oLCD_Enabled = (state_q == ST_PULSE);
    oLCD_RS      = oBusy ? rs_q : 1'b0;
    oLCD_Data    = nibble_sel(byte_q, hi_q);
  end

endmodule

// File: tb/tb_lcd_write_strobe.sv
// Directed bench for lcd_write_strobe: default-timing instance plus a
// minimum-timing instance (all phases one cycle).
module tb_lcd_write_strobe;

  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 1;
  localparam int G  = 50;
  localparam int PO = 2000;
`ifdef LCD_POST_WAIT_EN
  localparam int POST_ADD = PO;
`else
  localparam int POST_ADD = 0;
`endif
  localparam int EXP_R1   = 1 + S;
  localparam int EXP_R2   = S + P + H + G + S + 1;
  localparam int EXP_DONE = 2 * (S + P + H) + G + 1 + POST_ADD;
  localparam int BUDGET   = 3000;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       iStart = 1'b0;
  logic [7:0] iData = '0;
  logic       iRS = 1'b0;
  logic [3:0] oLCD_Data;
  logic       oLCD_RS, oLCD_Enabled, oBusy, oDone;

  logic       startB = 1'b0;
  logic [7:0] dataB = '0;
  logic       rsB = 1'b0;
  logic [3:0] dataB_o;
  logic       rsB_o, enB_o, busyB_o, doneB_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lcd_write_strobe #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H),
    .GAP_CYCLES(G), .POST_CYCLES(PO), .CNT_W(12)
  ) dut (
    .Clock(clk), .Reset(Reset), .iStart(iStart), .iData(iData), .iRS(iRS),
    .oLCD_Data(oLCD_Data), .oLCD_RS(oLCD_RS), .oLCD_Enabled(oLCD_Enabled),
    .oBusy(oBusy), .oDone(oDone)
  );

  lcd_write_strobe #(
    .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1),
    .GAP_CYCLES(1), .POST_CYCLES(1), .CNT_W(4)
  ) dut_min (
    .Clock(clk), .Reset(Reset), .iStart(startB), .iData(dataB), .iRS(rsB),
    .oLCD_Data(dataB_o), .oLCD_RS(rsB_o), .oLCD_Enabled(enB_o),
    .oBusy(busyB_o), .oDone(doneB_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts a write from the current negedge and follows it to oDone.
  task automatic do_write(input logic [7:0] d, input logic rs, input bit hold,
                          input logic [3:0] eh, input logic [3:0] el,
                          input bit post_check, input int exp_wait);
    int c, wait_c, r1, r2, w1, w2, busy_n, rs_bad, done_c;
    logic [3:0] n1, n2;
    logic prev_en;
    iData = d; iRS = rs; iStart = 1'b1;
    wait_c = 0;
    do begin
      @(negedge clk);
      wait_c++;
    end while (!(oBusy && !oDone) && wait_c < 10);
    chk("accept_wait", wait_c, exp_wait);
    if (!hold) iStart = 1'b0;
    iData = ~d; iRS = ~rs;
    c = 1; r1 = 0; r2 = 0; w1 = 0; w2 = 0; busy_n = 0; rs_bad = 0; done_c = 0;
    n1 = '0; n2 = '0; prev_en = 1'b0;
    while (1) begin
      if (oBusy) busy_n++;
      if (oBusy && oLCD_RS !== rs) rs_bad++;
      if (oLCD_Enabled && !prev_en) begin
        if (r1 == 0) begin r1 = c; n1 = oLCD_Data; end
        else begin r2 = c; n2 = oLCD_Data; end
      end
      if (oLCD_Enabled) begin
        if (r2 == 0) w1++; else w2++;
      end
      prev_en = oLCD_Enabled;
      if (oDone) begin done_c = c; break; end
      if (c >= BUDGET) break;
      @(negedge clk);
      c++;
    end
    iStart = 1'b0;
    chk("rise1_cycle", r1, EXP_R1);
    chk("rise2_cycle", r2, EXP_R2);
    chk("pulse1_width", w1, P);
    chk("pulse2_width", w2, P);
    chk("hi_nibble", n1, eh);
    chk("lo_nibble", n2, el);
    chk("rs_errors", rs_bad, 0);
    chk("done_cycle", done_c, EXP_DONE);
    chk("busy_span", busy_n, EXP_DONE);
    if (post_check) begin
      @(negedge clk);
      chk("idle_busy", oBusy, 0);
      chk("idle_done", oDone, 0);
      chk("idle_en", oLCD_Enabled, 0);
      chk("idle_rs", oLCD_RS, 0);
      chk("idle_data_kept", oLCD_Data, el);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       rs;
    bit         hold;
    logic [3:0] eh;
    logic [3:0] el;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cnt, mask, done_c, busy_n;
    logic [3:0] nb1, nb2;
    vecs[0] = '{8'h28, 1'b0, 1'b0, 4'h2, 4'h8};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 4'hA, 4'h5};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 4'hF, 4'hF};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 4'h0, 4'h0};
    vecs[4] = '{8'h6C, 1'b0, 1'b1, 4'h6, 4'hC};

    repeat (3) @(negedge clk);
    Reset = 1'b0;
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_en", oLCD_Enabled, 0);
    chk("rst_rs", oLCD_RS, 0);
    chk("rst_data", oLCD_Data, 0);

    for (int i = 0; i < 5; i++)
      do_write(vecs[i].d, vecs[i].rs, vecs[i].hold, vecs[i].eh, vecs[i].el, 1'b1, 1);

    // Back-to-back: second start presented during DONE, accepted in the following IDLE.
    do_write(8'h3C, 1'b0, 1'b0, 4'h3, 4'hC, 1'b0, 1);
    do_write(8'hC3, 1'b1, 1'b0, 4'hC, 4'h3, 1'b1, 2);

    // Reset during the first enable pulse.
    iData = 8'h28; iRS = 1'b1; iStart = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (oBusy) iStart = 1'b0;
    end while (!oLCD_Enabled && cnt < 20);
    chk("mid_pulse_reached", oLCD_Enabled, 1);
    iStart = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    chk("abort_en", oLCD_Enabled, 0);
    chk("abort_busy", oBusy, 0);
    chk("abort_rs", oLCD_RS, 0);
    chk("abort_data", oLCD_Data, 0);
    cnt = 0; busy_n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (oDone) cnt++;
      if (oBusy) busy_n++;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_stays_idle", busy_n, 0);
    do_write(8'h28, 1'b0, 1'b0, 4'h2, 4'h8, 1'b1, 1);

    // Minimum-timing instance: every phase lasts one cycle.
    dataB = 8'h5A; rsB = 1'b1; startB = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!busyB_o && cnt < 5);
    startB = 1'b0;
    dataB = 8'h00;
    mask = 0; done_c = 0; busy_n = 0; nb1 = '0; nb2 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (busyB_o) busy_n++;
      if (enB_o) mask = mask | (1 << (c - 1));
      if (c == 2) nb1 = dataB_o;
      if (c == 6) nb2 = dataB_o;
      if (doneB_o) begin done_c = c; break; end
      @(negedge clk);
    end
    chk("min_en_pattern", mask, 'h22);
    chk("min_hi_nibble", nb1, 4'h5);
    chk("min_lo_nibble", nb2, 4'hA);
`ifdef LCD_POST_WAIT_EN
    chk("min_done_cycle", done_c, 9);
    chk("min_busy_span", busy_n, 9);
`else
    chk("min_done_cycle", done_c, 8);
    chk("min_busy_span", busy_n, 8);
`endif
    @(negedge clk);
    chk("min_idle_after", busyB_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
